// File: rtl/cp0_core.sv
// MIPS-style coprocessor 0: Count/Compare timer, Status/Cause/EPC/BadVAddr,
// exception entry/return bookkeeping and the interrupt request to the pipeline.
module cp0_core #(
    parameter int                 DATA_W     = 32,
    parameter int                 NUM_HW_INT = 6,
    parameter int                 COUNT_DIV  = 1,
    parameter logic [DATA_W-1:0]  PRID_VAL   = 32'h004C0102,
    parameter logic [DATA_W-1:0]  CONFIG_VAL = 32'h00008000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [DATA_W-1:0]     rdata_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [DATA_W-1:0]     exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [DATA_W-1:0]     exc_badaddr_i,
    input  logic                  eret_i,
    output logic [DATA_W-1:0]     status_o,
    output logic [DATA_W-1:0]     cause_o,
    output logic [DATA_W-1:0]     epc_o,
    output logic [DATA_W-1:0]     count_o,
    output logic [DATA_W-1:0]     compare_o,
    output logic                  timer_int_o,
    output logic                  int_req_o
);

    localparam int            PW      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;
    localparam logic [4:0] A_PRID     = 5'd15;
    localparam logic [4:0] A_CONFIG   = 5'd16;

    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic [DATA_W-1:0] epc;
    logic [DATA_W-1:0] badvaddr;
    logic [PW-1:0]     prescaler;
    logic              timer_int;

    logic [3:0]        cu;
    logic [7:0]        im;
    logic              exl;
    logic              ie;

    logic              bd;
    logic              iv;
    logic              wp;
    logic [1:0]        ip_sw;
    logic [4:0]        exc_code;
    logic [5:0]        hw_ip;
    logic [5:0]        hw_sample;
    logic [7:0]        ip;

    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] cause_word;

    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic badaddr_exc;

    assign wr_count    = we_i && (waddr_i == A_COUNT);
    assign wr_compare  = we_i && (waddr_i == A_COMPARE);
    assign wr_status   = we_i && (waddr_i == A_STATUS);
    assign wr_cause    = we_i && (waddr_i == A_CAUSE);
    assign wr_epc      = we_i && (waddr_i == A_EPC);
    assign badaddr_exc = exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5));

    always_comb begin
        hw_sample = '0;
        for (int k = 0; k < NUM_HW_INT; k++) begin
            hw_sample[k] = int_i[k];
        end
    end

    // The timer shares IP7 with the last hardware line.
    assign ip          = {hw_ip[5] | timer_int, hw_ip[4:0], ip_sw};
    assign status_word = DATA_W'({cu, 12'b0, im, 6'b0, exl, ie});
    assign cause_word  = DATA_W'({bd, 7'b0, iv, wp, 6'b0, ip, 1'b0, exc_code, 2'b0});

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            prescaler <= '0;
        end else if (wr_count) begin
            count     <= wdata_i;
            prescaler <= '0;
        end else if (prescaler == PRE_MAX) begin
            count     <= count + DATA_W'(1);
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // A Compare write both acknowledges the timer and masks a same-cycle match.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare   <= '0;
            timer_int <= 1'b0;
        end else if (wr_compare) begin
            compare   <= wdata_i;
            timer_int <= 1'b0;
        end else if ((compare != '0) && (count == compare)) begin
            timer_int <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cu  <= 4'h1;
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
        end else begin
            if (wr_status) begin
                cu <= wdata_i[31:28];
                im <= wdata_i[15:8];
                ie <= wdata_i[0];
            end
            if (exc_valid_i) begin
                exl <= 1'b1;
            end else if (eret_i) begin
                exl <= 1'b0;
            end else if (wr_status) begin
                exl <= wdata_i[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bd       <= 1'b0;
            iv       <= 1'b0;
            wp       <= 1'b0;
            ip_sw    <= '0;
            exc_code <= '0;
            hw_ip    <= '0;
        end else begin
            hw_ip <= hw_sample;
            if (wr_cause) begin
                iv    <= wdata_i[23];
                wp    <= wdata_i[22];
                ip_sw <= wdata_i[9:8];
            end
            if (exc_valid_i) begin
                exc_code <= exc_code_i;
                if (!exl) begin
                    bd <= exc_bd_i;
                end
            end
        end
    end

    // A nested exception keeps the original EPC and also blocks a software EPC write.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            if (exc_valid_i) begin
                if (!exl) begin
                    epc <= exc_pc_i;
                end
            end else if (wr_epc) begin
                epc <= wdata_i;
            end
            if (badaddr_exc) begin
                badvaddr <= exc_badaddr_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            A_BADVADDR: rdata_o = badvaddr;
            A_COUNT:    rdata_o = count;
            A_COMPARE:  rdata_o = compare;
            A_STATUS:   rdata_o = status_word;
            A_CAUSE:    rdata_o = cause_word;
            A_EPC:      rdata_o = epc;
            A_PRID:     rdata_o = PRID_VAL;
            A_CONFIG:   rdata_o = CONFIG_VAL;
            default:    rdata_o = '0;
        endcase
    end

    assign status_o    = status_word;
    assign cause_o     = cause_word;
    assign epc_o       = epc;
    assign count_o     = count;
    assign compare_o   = compare;
    assign timer_int_o = timer_int;
    assign int_req_o   = ie && !exl && ((ip & im) != 8'b0);

endmodule

// File: tb/tb_cp0_core.sv
// Scoreboard bench for cp0_core: an architectural register model predicts every
// cycle's outputs, a monitor compares them, and directed scenarios add fixed checks.
module tb_cp0_core;

    localparam int          DIV         = 4;
    localparam logic [31:0] PRID        = 32'h004C0102;
    localparam logic [31:0] CFG         = 32'h00008000;
    localparam logic [31:0] STATUS_MASK = 32'hF000FF03;
    localparam logic [31:0] CAUSE_SW    = 32'h00C00300;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  ints;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badaddr;
    logic        eret;
    logic [31:0] status, cause, epc, count, compare;
    logic        timer_int, int_req;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  ints;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] bad;
        logic        eret;
    } stim_t;

    typedef struct packed {
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] rdata;
        logic        timer;
        logic        int_req;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Architectural model: whole registers plus the sampled interrupt lines.
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad;
    logic [5:0]  m_ints;
    logic        m_timer;
    int          m_tick;

    cp0_core #(
        .DATA_W     (32),
        .NUM_HW_INT (6),
        .COUNT_DIV  (DIV),
        .PRID_VAL   (PRID),
        .CONFIG_VAL (CFG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .we_i          (we),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .raddr_i       (raddr),
        .rdata_o       (rdata),
        .int_i         (ints),
        .exc_valid_i   (exc_valid),
        .exc_code_i    (exc_code),
        .exc_pc_i      (exc_pc),
        .exc_bd_i      (exc_bd),
        .exc_badaddr_i (exc_badaddr),
        .eret_i        (eret),
        .status_o      (status),
        .cause_o       (cause),
        .epc_o         (epc),
        .count_o       (count),
        .compare_o     (compare),
        .timer_int_o   (timer_int),
        .int_req_o     (int_req)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_cause_word();
        return m_cause | {16'b0, m_ints[5] | m_timer, m_ints[4:0], 10'b0};
    endfunction

    function automatic logic m_int_req();
        logic [31:0] cw;
        cw = m_cause_word();
        return m_status[0] && !m_status[1] && ((cw[15:8] & m_status[15:8]) != 8'b0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause_word();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            5'd16:   return CFG;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input stim_t s);
        logic [31:0] old_count, old_compare, old_epc;
        logic        old_exl;
        if (s.rst) begin
            m_count = 0; m_compare = 0; m_cause = 0; m_epc = 0; m_bad = 0;
            m_status = 32'h10000000; m_ints = 0; m_timer = 1'b0; m_tick = 0;
        end else begin
            old_count   = m_count;
            old_compare = m_compare;
            old_epc     = m_epc;
            old_exl     = m_status[1];
            if (s.we && s.waddr == 5'd9) begin
                m_count = s.wdata;
                m_tick  = 0;
            end else begin
                m_tick++;
                if (m_tick == DIV) begin
                    m_tick  = 0;
                    m_count = m_count + 32'd1;
                end
            end
            if (s.we && s.waddr == 5'd11) begin
                m_compare = s.wdata;
                m_timer   = 1'b0;
            end else if (old_compare != 0 && old_count == old_compare) begin
                m_timer = 1'b1;
            end
            m_ints = s.ints;
            if (s.we && s.waddr == 5'd12) m_status = s.wdata & STATUS_MASK;
            if (s.eret) m_status[1] = 1'b0;
            if (s.exc)  m_status[1] = 1'b1;
            if (s.we && s.waddr == 5'd13) m_cause = (m_cause & ~CAUSE_SW) | (s.wdata & CAUSE_SW);
            if (s.we && s.waddr == 5'd14) m_epc = s.wdata;
            if (s.exc) begin
                m_cause[6:2] = s.code;
                if (!old_exl) m_cause[31] = s.bd;
                m_epc = old_exl ? old_epc : s.pc;
                if (s.code == 5'd4 || s.code == 5'd5) m_bad = s.bad;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; we = s.we; waddr = s.waddr; wdata = s.wdata; raddr = s.raddr;
        ints = s.ints; exc_valid = s.exc; exc_code = s.code; exc_pc = s.pc;
        exc_bd = s.bd; exc_badaddr = s.bad; eret = s.eret;
        model_step(s);
        e.count   = m_count;
        e.compare = m_compare;
        e.status  = m_status;
        e.cause   = m_cause_word();
        e.epc     = m_epc;
        e.rdata   = m_read(s.raddr);
        e.timer   = m_timer;
        e.int_req = m_int_req();
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    function automatic stim_t idle(input logic [4:0] ra);
        stim_t s;
        s = '0;
        s.raddr = ra;
        return s;
    endfunction

    function automatic stim_t wr(input logic [4:0] a, input logic [31:0] d);
        stim_t s;
        s = idle(a);
        s.we = 1'b1;
        s.waddr = a;
        s.wdata = d;
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("sb count",   count,   e.count);
                checkOutput("sb compare", compare, e.compare);
                checkOutput("sb status",  status,  e.status);
                checkOutput("sb cause",   cause,   e.cause);
                checkOutput("sb epc",     epc,     e.epc);
                checkOutput("sb rdata",   rdata,   e.rdata);
                checkOutput("sb timer",   32'(timer_int), 32'(e.timer));
                checkOutput("sb int_req", 32'(int_req),   32'(e.int_req));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        int    exp_cnt[4] = '{0, 0, 0, 1};
        int    idx_c, idx_t;
        logic [4:0] addr_tab[9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; ints = '0;
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badaddr = '0; eret = 1'b0;

        s = idle(5'd15); s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("reset prid", rdata, PRID);
        s = idle(5'd16); s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("reset config", rdata, CFG);
        s = idle(5'd9); s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("reset status", status, 32'h10000000);
        checkOutput("reset cause",  cause,  32'h0);
        checkOutput("div count 1",  rdata,  32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(idle(5'd9));
            checkOutput($sformatf("div count %0d", i + 2), rdata, 32'(exp_cnt[i]));
        end

        applyStimulus(wr(5'd11, 32'd10));
        applyStimulus(wr(5'd9, 32'd5));
        checkOutput("count loaded", count, 32'd5);
        idx_c = -1;
        idx_t = -1;
        for (int i = 0; i < 60 && idx_t < 0; i++) begin
            applyStimulus(idle(5'd9));
            if (idx_c < 0 && count == 32'd10) idx_c = i;
            if (timer_int) idx_t = i;
        end
        checkOutput("timer rise delay", 32'(idx_t - idx_c), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(idle(5'd11));
        checkOutput("timer sticky", 32'(timer_int), 32'd1);
        applyStimulus(wr(5'd11, 32'd20));
        checkOutput("timer cleared", 32'(timer_int), 32'd0);

        applyStimulus(wr(5'd11, 32'd0));
        s = wr(5'd12, 32'h10000401); s.ints = 6'b000001;
        applyStimulus(s);
        checkOutput("cause ip2", 32'(cause[10]), 32'd1);
        checkOutput("int_req on", 32'(int_req), 32'd1);
        s = wr(5'd12, 32'h10000403); s.ints = 6'b000001;
        applyStimulus(s);
        checkOutput("int_req exl", 32'(int_req), 32'd0);

        applyStimulus(wr(5'd12, 32'h10000000));
        s = idle(5'd8); s.exc = 1'b1; s.code = 5'd4; s.pc = 32'h80; s.bd = 1'b1; s.bad = 32'h1003;
        applyStimulus(s);
        checkOutput("exc epc",      epc,   32'h80);
        checkOutput("exc badvaddr", rdata, 32'h1003);
        checkOutput("exc cause",    cause, 32'h80000010);
        checkOutput("exc exl",      32'(status[1]), 32'd1);
        s = idle(5'd14); s.exc = 1'b1; s.code = 5'd0; s.pc = 32'h90;
        applyStimulus(s);
        checkOutput("nested epc",   epc,   32'h80);
        checkOutput("nested cause", cause, 32'h80000000);

        s = wr(5'd12, 32'h0); s.exc = 1'b1; s.code = 5'd8; s.pc = 32'hA0; s.eret = 1'b1;
        applyStimulus(s);
        checkOutput("priority status", status, 32'h00000002);

        s = wr(5'd9, 32'h55); s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("rst beats write", count, 32'h0);
        checkOutput("rst status", status, 32'h10000000);

        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rst   = ($urandom_range(0, 99) == 0);
            s.we    = 1'(($urandom_range(0, 1)));
            s.waddr = addr_tab[$urandom_range(0, 8)];
            if (s.waddr == 5'd0) s.waddr = 5'($urandom_range(0, 31));
            s.wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 24)) : $urandom;
            s.raddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : addr_tab[$urandom_range(0, 7)];
            s.ints  = 6'($urandom);
            s.exc   = ($urandom_range(0, 7) == 0);
            s.code  = ($urandom_range(0, 2) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            s.pc    = $urandom;
            s.bd    = 1'(($urandom_range(0, 1)));
            s.bad   = $urandom;
            s.eret  = ($urandom_range(0, 7) == 0);
            applyStimulus(s);
        end

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_core.md
CP0_CORE -- requirements
Module: cp0_core

Interface
REQ-001 SHALL have parameter DATA_W, 32, width of every CP0 register and data port.
REQ-002 SHALL have parameter NUM_HW_INT, 6, number of hardware interrupt inputs (legal 1..6).
REQ-003 SHALL have parameter COUNT_DIV, 1, Count increments once every COUNT_DIV clocks (legal 1..256).
REQ-004 SHALL have parameter PRID_VAL, 32'h004C0102, constant PRId contents.
REQ-005 SHALL have parameter CONFIG_VAL, 32'h00008000, constant Config contents.
REQ-006 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports we_i  in  1  register write enable; waddr_i  in  5  write address; wdata_i  in  DATA_W  write data.
REQ-009 SHALL have ports raddr_i  in  5  read address; rdata_o  out  DATA_W  read data.
REQ-010 SHALL have port int_i  in  NUM_HW_INT  level hardware interrupts.
REQ-011 SHALL have ports exc_valid_i  in  1  exception taken; exc_code_i  in  5  ExcCode; exc_pc_i  in  DATA_W  faulting PC; exc_bd_i  in  1  faulting instr in delay slot; exc_badaddr_i  in  DATA_W  faulting address.
REQ-012 SHALL have port eret_i  in  1  exception return.
REQ-013 SHALL have outputs status_o, cause_o, epc_o, count_o, compare_o  DATA_W each, current register values.
REQ-014 SHALL have outputs timer_int_o  1  timer interrupt pending; int_req_o  1  interrupt request to pipeline.

Function
REQ-015 SHALL map addresses: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
REQ-016 SHALL drive rdata_o combinationally from raddr_i; unmapped address -> 0; same-cycle write not forwarded (old value read).
REQ-017 SHALL use a prescaler counting 0..COUNT_DIV-1; Count +1 (mod 2^DATA_W) when prescaler = COUNT_DIV-1; COUNT_DIV=1 -> every clock.
REQ-018 SHALL on Count write load wdata_i, clear prescaler, suppress that cycle's increment.
REQ-019 SHALL set timer_int_o the clock after Compare != 0 and Count == Compare; sticky until Compare written.
REQ-020 SHALL on Compare write load wdata_i and clear timer_int_o; a simultaneous match does not set it.
REQ-021 SHALL sample Cause.IP[2+k] = int_i[k] every clock for k < NUM_HW_INT; unused IP[7:2] bits 0; IP7 = int_i[5] OR timer_int_o.
REQ-022 SHALL allow software writes of Cause only to IP[1:0], IV(23), WP(22); other bits ignored.
REQ-023 SHALL allow writes to Status bits CU[31:28], IM[15:8], EXL(1), IE(0); other bits read 0.
REQ-024 SHALL allow software writes of EPC in full; BadVAddr, PRId, Config read-only.
REQ-025 SHALL on exc_valid_i: Cause.ExcCode[6:2] <= exc_code_i; Status.EXL <= 1; if EXL was 0, EPC <= exc_pc_i and Cause.BD(31) <= exc_bd_i, else EPC/BD unchanged.
REQ-026 SHALL on exc_valid_i with exc_code_i = 4 or 5 load BadVAddr <= exc_badaddr_i; other codes leave it.
REQ-027 SHALL on eret_i clear Status.EXL.
REQ-028 SHALL give priority exc_valid_i > eret_i > software write for any overlapping field in one cycle; non-overlapping fields of a software write still take effect.
REQ-029 SHALL drive int_req_o = Status.IE AND NOT Status.EXL AND OR(Cause.IP[7:0] AND Status.IM[7:0]), combinational from registered state.

Reset
REQ-030 SHALL on rst: Count, Compare, Cause, EPC, BadVAddr, prescaler = 0; Status = 32'h10000000; timer_int_o = 0.
REQ-031 SHALL make rst override every concurrent write, exception, and eret; outputs reach reset values the clock after rst sampled high.
REQ-032 SHALL read PRId = PRID_VAL and Config = CONFIG_VAL at all times including reset.

Verification
REQ-033 SHALL cover: COUNT_DIV=4, release reset -> Count reads 0,0,0,0,1 on clocks 1..5 after reset.
REQ-034 SHALL cover: write Compare=10, Count=5 -> timer_int_o rises when Count becomes 10 (+1 clock), stays high; write Compare=20 -> clears next clock.
REQ-035 SHALL cover: Status=32'h10000401, int_i[0]=1 -> Cause[10]=1 next clock, int_req_o=1; set EXL -> int_req_o=0.
REQ-036 SHALL cover: exc_valid_i code 4, pc 0x80, badaddr 0x1003, bd=1 -> EPC 0x80, BadVAddr 0x1003, Cause 0x80000010, EXL=1; second exception pc 0x90 -> EPC stays 0x80.
REQ-037 SHALL cover: same cycle exc_valid_i, eret_i, write Status=0 -> EXL=1, IE=0.
REQ-038 SHALL cover: rst asserted together with Count write 0x55 -> Count 0 next clock.
